// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates four requesters for a shared 8-digit display.
// A granted value is held for at least DWELL_CYCLES clocks; the current owner
// may refresh its value during the dwell without restarting it. A free-running
// divider produces scan_tick for the digit-select logic.
// Optional build macro: DISP_SCHED_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin arbitration.
module display_scheduler #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned REFRESH_DIV  = 100_000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [3:0]   i_req,
  input  logic [127:0] i_req_data,
  output logic [3:0]   o_ack,
  output logic [31:0]  o_disp_num,
  output logic [1:0]   o_disp_owner,
  output logic         o_disp_valid,
  output logic         o_scan_tick
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 32;
  localparam int unsigned RW   = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_capture;
  logic            w_grant;
  logic            w_refresh;
  logic [1:0]      w_win;
  logic [1:0]      r_win;
  logic [DW-1:0]   r_win_data;
  logic [CW-1:0]   r_dwell;
  logic [RW-1:0]   r_refresh_cnt;
  logic [3:0]      r_ack;
  logic [DW-1:0]   r_disp_num;
  logic [1:0]      r_disp_owner;
  logic            r_disp_valid;
  logic            r_scan_tick;

`ifdef DISP_SCHED_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    w_win = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (i_req[i]) w_win = 2'(i);
    end
  end
`else
  logic [1:0] r_last;
  logic [1:0] w_idx;

  // Round-robin: search starts one past the last winner.
  always_comb begin
    w_win = r_last;
    w_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      w_idx = r_last + 2'(k) + 2'd1;
      if (i_req[w_idx]) w_win = w_idx;
    end
  end

  // Round-robin pointer tracks the most recent winner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 2'd3;
    end else if (w_capture) begin
      r_last <= w_win;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_grant     = 1'b0;
    w_refresh   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_capture   = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        w_grant     = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_dwell == '0) begin
          // Expiry: arbitration wins over an owner refresh in the same cycle.
          if (|i_req) begin
            w_capture   = 1'b1;
            w_state_nxt = S_GRANT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (i_req[r_disp_owner]) begin
          w_refresh = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Winner capture, display registers, ack pulse and dwell counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win        <= '0;
      r_win_data   <= '0;
      r_ack        <= '0;
      r_disp_num   <= '0;
      r_disp_owner <= '0;
      r_disp_valid <= 1'b0;
      r_dwell      <= '0;
    end else begin
      r_ack <= '0;
      if (w_capture) begin
        r_win      <= w_win;
        r_win_data <= i_req_data[{w_win, 5'd0} +: DW];
      end
      if (w_grant) begin
        r_disp_num   <= r_win_data;
        r_disp_owner <= r_win;
        r_disp_valid <= 1'b1;
        r_ack        <= 4'b0001 << r_win;
        r_dwell      <= CW'(DWELL_CYCLES - 1);
      end else if ((r_state == S_HOLD) && (r_dwell != '0)) begin
        r_dwell <= r_dwell - CW'(1);
      end
      if (w_refresh) begin
        r_disp_num <= i_req_data[{r_disp_owner, 5'd0} +: DW];
        r_ack      <= 4'b0001 << r_disp_owner;
      end
    end
  end

  // Free-running scan divider, independent of the FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_refresh_cnt <= '0;
      r_scan_tick   <= 1'b0;
    end else if (r_refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      r_refresh_cnt <= '0;
      r_scan_tick   <= 1'b1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + RW'(1);
      r_scan_tick   <= 1'b0;
    end
  end

  assign o_ack        = r_ack;
  assign o_disp_num   = r_disp_num;
  assign o_disp_owner = r_disp_owner;
  assign o_disp_valid = r_disp_valid;
  assign o_scan_tick  = r_scan_tick;

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 50_000_000: minimum clocks a granted value stays on the display before another requester may take it; legal range 2..2^32-1.
REQ-002 Parameter REFRESH_DIV, default 100_000: clocks between scan_tick pulses; legal range 2..2^24-1.
REQ-003 clock  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester display request; level, held until ack.
REQ-006 req_data  input  128  requester i value on bits [32i+31:32i].
REQ-007 ack  output  4  one-hot, one-cycle pulse; marks the cycle req_data[i] is captured.
REQ-008 disp_num  output  32  registered value driven to the 8-digit display datapath.
REQ-009 disp_owner  output  2  index of the requester that owns disp_num.
REQ-010 disp_valid  output  1  high once any value has been captured since reset.
REQ-011 scan_tick  output  1  one-cycle pulse every REFRESH_DIV clocks; advances the digit-select counter.

Function
REQ-012 FSM states IDLE, GRANT, HOLD, encoded in 2 bits; unused code returns to IDLE.
REQ-013 IDLE: any req high -> select winner and go to GRANT next cycle; else stay in IDLE.
REQ-014 GRANT (exactly 1 cycle): disp_num <= winner data, disp_owner <= winner, ack[winner]=1, disp_valid <= 1, dwell counter <= DWELL_CYCLES-1, then go to HOLD.
REQ-015 The winner and its req_data are sampled in the cycle before GRANT and registered, so a req dropped during GRANT does not cancel the capture.
REQ-016 HOLD: dwell counter decrements each cycle; at 0 -> any req high -> GRANT, else IDLE.
REQ-017 In HOLD, req from the current owner (req[disp_owner]=1) updates disp_num the next cycle with an ack pulse; the dwell counter does not restart.
REQ-018 In HOLD, requests from non-owners are not acked until dwell expiry.
REQ-019 Arbitration is round-robin: the search starts at last winner+1 (mod 4).
REQ-020 When dwell expiry and owner refresh coincide, arbitration takes precedence and the owner competes under round-robin order.
REQ-021 ack never has more than one bit set, and is never high outside GRANT or an owner refresh.
REQ-022 In IDLE, disp_num, disp_owner and disp_valid hold their last values; the display is never blanked by the scheduler.
REQ-023 scan_tick comes from a free-running counter independent of the FSM: a pulse when the counter equals REFRESH_DIV-1, then wrap to 0.
REQ-024 Latency from req rising in IDLE to disp_num update is 2 clocks.

Reset
REQ-025 reset low asynchronously forces: state IDLE, disp_num 0, disp_owner 0, disp_valid 0, ack 0, scan_tick 0, dwell and refresh counters 0, round-robin pointer to 3 (so requester 0 is searched first).
REQ-026 Reset asserted mid-GRANT or mid-HOLD aborts the transaction with no ack pulse; after release, operation restarts from IDLE on the first rising edge.

Configuration
REQ-027 Macro DISP_SCHED_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest index wins) and the round-robin pointer is removed; when undefined, round-robin per REQ-019 applies.

Verification
REQ-028 Reset, then req=4'b0001 with data0=0x12345678 -> ack=0001 two clocks later, disp_num=0x12345678, disp_owner=0, disp_valid=1.
REQ-029 DWELL_CYCLES=8, req=4'b1111 held -> grants in order 0,1,2,3,0, each 9 clocks apart (round-robin); with the macro defined, grants are always 0.
REQ-030 Owner 2 in HOLD changes data2 to 0xCAFEF00D and pulses req[2] -> ack[2] the next cycle, disp_num updated, dwell expiry cycle unchanged.
REQ-031 REFRESH_DIV=4 -> scan_tick high on clocks 3,7,11 after reset release, unaffected by req traffic.
REQ-032 Assert reset during HOLD with req[1] pending -> all outputs 0 immediately and no ack; after release, req[1] is granted via IDLE->GRANT.
REQ-033 Dwell expiry with no req -> state IDLE, disp_num retained, ack stays 0.
